mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port synchronous RAM/IO-page memory between two requesters:
//  M0 = RISC-V core (high priority), M1 = secondary master (UART boot loader / DMA).
//  Sits between the masters and the Memory port (mem_addr/rdata/rstrb/wdata/wmask).
//  Fixed priority to M0, with a starvation guard that forces an M1 grant after a wait limit.
//  Routes the 1-cycle-latency read data back to the master that issued the read.
// PARAMETERS
//  ADDR_W        32  address width; all data paths fixed at 32 bits
//  STARVE_LIMIT  8   max consecutive cycles M1 may wait with M0 busy before M1 is forced
//  CNT_W         4   width of the starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk        in   1       system clock
//  resetn     in   1       asynchronous active-low reset
//  m0_addr    in   ADDR_W  M0 byte address
//  m0_wdata   in   32      M0 store data
//  m0_wmask   in   4       M0 byte write mask (SW/SH/SB)
//  m0_rstrb   in   1       M0 read request
//  m0_gnt     out  1       M0 access accepted this cycle
//  m0_rdata   out  32      M0 read data
//  m0_rvalid  out  1       m0_rdata valid (cycle after granted read)
//  m1_*       same set for M1 (m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_gnt, m1_rdata, m1_rvalid)
//  mem_addr   out  ADDR_W  to Memory
//  mem_wdata  out  32      to Memory
//  mem_wmask  out  4       to Memory
//  mem_rstrb  out  1       to Memory
//  mem_rdata  in   32      from Memory, valid 1 cycle after mem_rstrb
// BEHAVIOUR
//  - mX_req = mX_rstrb | (|mX_wmask); master holds addr/data/strobes stable until mX_gnt.
//  - Same cycle: at most one grant; grant is combinational. Granted master's addr/wdata/wmask/rstrb
//    drive mem_*. No grant -> mem_rstrb=0 and mem_wmask=0; mem_addr/mem_wdata=0.
//  - Priority: M0 unless starve_cnt==STARVE_LIMIT and m1_req, then M1.
//  - Read and write in one request (rstrb and wmask both set): legal, passed through unchanged.
//  - starve_cnt: increments when m1_req and not m1_gnt (saturates at STARVE_LIMIT).
//    Clears on m1_gnt or when m1_req=0.
//  - Read return: registered tag rd_owner{valid,id} set on a granted read. Next cycle
//    mX_rvalid=1 for the owner only. Both mX_rdata = mem_rdata unconditionally (qualify with rvalid).
//  - Back-to-back reads from different masters: each rvalid is in the cycle after its own grant.
//    No bubbles between them.
//  - Write-only grant: no rvalid.
//  - Reset (async, resetn=0): starve_cnt=0, rd_owner cleared, all gnt/rvalid=0,
//    mem_rstrb=0, mem_wmask=0.
//    Reset mid-read drops the pending rvalid; no return after release.
//  - Release: first grant possible in the first clk edge with resetn=1.
// CONFIGURATION
//  MEM_ARB_LOCK_EN defined: adds input m1_lock (1).
//   - While m1_lock=1 and M1 was granted last cycle, M1 keeps priority over M0 (burst/atomic loader writes).
//   - starve_cnt is held during the lock.
//   - Lock ends on the first cycle with m1_lock=0 or m1_req=0.
//  Not defined: no m1_lock port; pure fixed priority + starvation guard as above.
// TESTING
//  - Reset: resetn=0 with both reqs high -> no gnt, mem_wmask=0, mem_rstrb=0. Release -> m0_gnt next edge.
//  - M0 read 0x0000_0010 alone -> m0_gnt same cycle, mem_addr=0x10.
//    Next cycle m0_rvalid=1, m0_rdata=MEM[4]. m1_rvalid stays 0.
//  - M1 SW 0x0040_0008, data 0x41, wmask=4'b1111, M0 idle -> m1_gnt, mem_wmask=4'b1111. No rvalid.
//  - M0 requests every cycle, M1 read pending -> m1_gnt exactly on the 9th cycle of waiting (STARVE_LIMIT=8).
//    m0_gnt=0 that cycle. starve_cnt then clears.
//  - Alternating reads M0@0x20, M1@0x24 back-to-back -> rvalids alternate 1 cycle after each grant,
//    each with correct word.
//  - MEM_ARB_LOCK_EN: M1 locks a 4-word write burst while M0 requests -> 4 consecutive m1_gnt,
//    then m0_gnt after lock drops.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port RAM/IO page between the core (M0) and a loader/DMA (M1).
// Optional M1 burst lock is compiled in when MEM_ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic              m0_gnt,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
`ifdef MEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_gnt,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic             m0_req_s;
  logic             m1_req_s;
  logic             starved_s;
  logic             lock_act_s;
  logic             m0_gnt_s;
  logic             m1_gnt_s;
  logic             rd_issue_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  logic             rd_valid_r;
  logic             rd_id_r;

  assign m0_req_s  = m0_rstrb | (|m0_wmask);
  assign m1_req_s  = m1_rstrb | (|m1_wmask);
  assign starved_s = m1_req_s & (starve_cnt_r == LIMIT_C);

`ifdef MEM_ARB_LOCK_EN
  logic m1_last_r;

  // A lock only continues an M1 grant that already happened last cycle.
  assign lock_act_s = m1_lock & m1_req_s & m1_last_r;

  // Remember whether M1 owned the bus in the previous cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m1_last_r <= 1'b0;
    end else begin
      m1_last_r <= m1_gnt_s;
    end
  end
`else
  assign lock_act_s = 1'b0;
`endif

  // Fixed priority to M0, overridden by starvation or an active M1 lock; nothing granted in reset.
  always_comb begin
    m0_gnt_s = 1'b0;
    m1_gnt_s = 1'b0;
    if (!resetn) begin
      m0_gnt_s = 1'b0;
      m1_gnt_s = 1'b0;
    end else if (m1_req_s && (!m0_req_s || starved_s || lock_act_s)) begin
      m1_gnt_s = 1'b1;
    end else if (m0_req_s) begin
      m0_gnt_s = 1'b1;
    end else begin
      m0_gnt_s = 1'b0;
      m1_gnt_s = 1'b0;
    end
  end

  // Steer the granted master onto the memory port; idle bus is driven to zero.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'h0000_0000;
    mem_wmask = 4'b0000;
    mem_rstrb = 1'b0;
    case ({m1_gnt_s, m0_gnt_s})
      2'b01: begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wmask = m0_wmask;
        mem_rstrb = m0_rstrb;
      end
      2'b10: begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wmask = m1_wmask;
        mem_rstrb = m1_rstrb;
      end
      default: begin
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 32'h0000_0000;
        mem_wmask = 4'b0000;
        mem_rstrb = 1'b0;
      end
    endcase
  end

  // Count cycles M1 has waited; a lock freezes the count, a grant or idle M1 clears it.
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (lock_act_s) begin
      starve_cnt_nxt_s = starve_cnt_r;
    end else if (!m1_req_s || m1_gnt_s) begin
      starve_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (starve_cnt_r == LIMIT_C) begin
      starve_cnt_nxt_s = starve_cnt_r;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rd_issue_s = (m0_gnt_s & m0_rstrb) | (m1_gnt_s & m1_rstrb);

  // Starvation counter and read-return owner tag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= {CNT_W{1'b0}};
      rd_valid_r   <= 1'b0;
      rd_id_r      <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
      rd_valid_r   <= rd_issue_s;
      rd_id_r      <= m1_gnt_s;
    end
  end

  assign m0_gnt    = m0_gnt_s;
  assign m1_gnt    = m1_gnt_s;
  assign m0_rvalid = rd_valid_r & ~rd_id_r;
  assign m1_rvalid = rd_valid_r & rd_id_r;
  // Read data is broadcast; the rvalid qualifies which master consumes it.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed sequences, a vector table and a random run
// against a cycle-level reference model (lock tests compile in with MEM_ARB_LOCK_EN).
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
  logic [3:0]  m0_wmask = 4'h0;
  logic        m0_rstrb = 1'b0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
  logic [3:0]  m1_wmask = 4'h0;
  logic        m1_rstrb = 1'b0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic        m1_lock = 1'b0;
`endif
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;

  mem_bus_arbiter #(.ADDR_W(32), .STARVE_LIMIT(STARVE), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
`ifdef MEM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory device: 256 words, registered read of the pre-write contents.
  logic [31:0] mem [256];
  logic        load_mem = 1'b1;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] ref_mem [256];
  int          ref_wait = 0;
  logic        ref_rd_valid = 1'b0, ref_rd_id = 1'b0, ref_m1_last = 1'b0;
  logic [31:0] ref_rd_data = 32'h0;
  logic        last_e0 = 1'b0, last_e1 = 1'b0;
  // Sampled DUT outputs of the last cycle
  logic        s_m0_gnt, s_m1_gnt, s_m0_rvalid, s_m1_rvalid, s_rstrb;
  logic [31:0] s_addr, s_m0_rdata;
  logic [3:0]  s_wmask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic r0, r1, e0, e1, lk, er;
    logic [31:0] ea, ed;
    logic [3:0] em;
    int idx;
    @(negedge clk);
    r0 = m0_rstrb | (|m0_wmask);
    r1 = m1_rstrb | (|m1_wmask);
    if (!resetn) begin
      ref_wait = 0; ref_rd_valid = 1'b0; ref_m1_last = 1'b0;
    end
    lk = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    lk = m1_lock && r1 && ref_m1_last;
`endif
    e1 = resetn && r1 && (!r0 || ref_wait >= STARVE || lk);
    e0 = resetn && r0 && !e1;
    ea = e0 ? m0_addr  : (e1 ? m1_addr  : 32'h0);
    ed = e0 ? m0_wdata : (e1 ? m1_wdata : 32'h0);
    em = e0 ? m0_wmask : (e1 ? m1_wmask : 4'h0);
    er = (e0 && m0_rstrb) || (e1 && m1_rstrb);
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_wmask", 32'(mem_wmask), 32'(em));
    chk("mem_rstrb", 32'(mem_rstrb), 32'(er));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(ref_rd_valid && !ref_rd_id));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(ref_rd_valid && ref_rd_id));
    if (ref_rd_valid && !ref_rd_id) chk("m0_rdata", m0_rdata, ref_rd_data);
    if (ref_rd_valid && ref_rd_id)  chk("m1_rdata", m1_rdata, ref_rd_data);
    s_m0_gnt = m0_gnt; s_m1_gnt = m1_gnt; s_addr = mem_addr; s_wmask = mem_wmask;
    s_rstrb = mem_rstrb; s_m0_rvalid = m0_rvalid; s_m1_rvalid = m1_rvalid; s_m0_rdata = m0_rdata;
    idx = int'(ea[9:2]);
    ref_rd_valid = er;
    ref_rd_id    = e1;
    ref_rd_data  = ref_mem[idx];
    for (int b = 0; b < 4; b++) if (em[b]) ref_mem[idx][8*b +: 8] = ed[8*b +: 8];
    if (lk) ref_wait = ref_wait;
    else if (!r1 || e1) ref_wait = 0;
    else ref_wait = ref_wait + 1;
    ref_m1_last = e1;
    last_e0 = e0; last_e1 = e1;
    @(posedge clk); #1;
  endtask

  task automatic set_m0(input logic rs, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] d);
    m0_rstrb = rs; m0_wmask = wm; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic rs, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] d);
    m1_rstrb = rs; m1_wmask = wm; m1_addr = a; m1_wdata = d;
  endtask

  task automatic rand_req(input int idle_pct, output logic rs, output logic [3:0] wm,
                          output logic [31:0] a, output logic [31:0] d);
    logic [3:0] masks [8];
    masks = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    if (int'($urandom_range(0, 99)) < idle_pct) begin
      rs = 1'b0; wm = 4'h0; a = 32'h0; d = 32'h0;
    end else begin
      wm = masks[$urandom_range(0, 7)];
      rs = 1'($urandom_range(0, 1));
      if (wm == 4'h0) rs = 1'b1;
      a = 32'($urandom_range(0, 255)) << 2;
      d = $urandom;
    end
  endtask

  typedef struct {
    logic m0_rs; logic [3:0] m0_wm; logic [31:0] m0_a; logic [31:0] m0_d;
    logic m1_rs; logic [3:0] m1_wm; logic [31:0] m1_a; logic [31:0] m1_d;
    logic e_g0; logic e_g1; logic [31:0] e_addr; logic [3:0] e_wm; logic e_rs;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int n;
    logic rs; logic [3:0] wm; logic [31:0] a, d;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    vecs[0] = '{1'b1, 4'h0, 32'h100, 32'h0,  1'b0, 4'h0, 32'h0,   32'h0,  1'b1, 1'b0, 32'h100, 4'h0, 1'b1};
    vecs[1] = '{1'b0, 4'h0, 32'h0,   32'h0,  1'b0, 4'h3, 32'h104, 32'h55, 1'b0, 1'b1, 32'h104, 4'h3, 1'b0};
    vecs[2] = '{1'b0, 4'hF, 32'h108, 32'h77, 1'b1, 4'h0, 32'h10C, 32'h0,  1'b1, 1'b0, 32'h108, 4'hF, 1'b0};
    vecs[3] = '{1'b0, 4'h0, 32'h0,   32'h0,  1'b1, 4'h0, 32'h10C, 32'h0,  1'b0, 1'b1, 32'h10C, 4'h0, 1'b1};
    vecs[4] = '{1'b1, 4'h4, 32'h110, 32'hAB0000, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h110, 4'h4, 1'b1};
    vecs[5] = '{1'b0, 4'h0, 32'h0,   32'h0,  1'b0, 4'h0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,   4'h0, 1'b0};
    vecs[6] = '{1'b0, 4'h0, 32'h0,   32'h0,  1'b1, 4'h8, 32'h114, 32'hCD000000, 1'b0, 1'b1, 32'h114, 4'h8, 1'b1};
    vecs[7] = '{1'b0, 4'h0, 32'h0,   32'h0,  1'b0, 4'h1, 32'h118, 32'hEF, 1'b0, 1'b1, 32'h118, 4'h1, 1'b0};

    // Reset with both masters requesting: nothing may reach memory
    set_m0(1'b1, 4'h0, 32'h10, 32'h0);
    set_m1(1'b1, 4'h0, 32'h24, 32'h0);
    cycle();
    cycle();
    chk("rst_no_gnt", 32'({s_m0_gnt, s_m1_gnt}), 32'h0);
    chk("rst_wmask", 32'(s_wmask), 32'h0);
    load_mem = 1'b0;
    resetn = 1'b1;
    cycle();
    chk("rel_m0_gnt", 32'(s_m0_gnt), 32'h1);
    chk("rd10_addr", s_addr, 32'h10);
    set_m0(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    chk("rd10_rvalid", 32'(s_m0_rvalid), 32'h1);
    chk("rd10_data", s_m0_rdata, 32'hA500_0004);
    set_m1(1'b0, 4'hF, 32'h0040_0008, 32'h41);
    cycle();
    chk("sw_m1_gnt", 32'(s_m1_gnt), 32'h1);
    chk("sw_wmask", 32'(s_wmask), 32'hF);
    set_m1(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    chk("sw_no_rvalid", 32'({s_m0_rvalid, s_m1_rvalid}), 32'h0);

    // Starvation: M0 busy every cycle, M1 read waits; two rounds prove the counter clears
    set_m0(1'b1, 4'h0, 32'h30, 32'h0);
    for (int round = 0; round < 2; round++) begin
      set_m1(1'b1, 4'h0, 32'h0040_0008, 32'h0);
      n = 0;
      do begin n++; cycle(); end while (!s_m1_gnt && n < 20);
      chk("starve_cycle", 32'(n), 32'd9);
      chk("starve_m0_off", 32'(s_m0_gnt), 32'h0);
    end
    set_m1(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    set_m0(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();

    // Alternating back-to-back reads
    for (int k = 0; k < 4; k++) begin
      set_m0(1'b1, 4'h0, 32'h20, 32'h0); set_m1(1'b0, 4'h0, 32'h0, 32'h0);
      cycle();
      set_m0(1'b0, 4'h0, 32'h0, 32'h0);  set_m1(1'b1, 4'h0, 32'h24, 32'h0);
      cycle();
      chk("alt_m0_rvalid", 32'(s_m0_rvalid), 32'h1);
    end
    set_m1(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    chk("alt_m1_rvalid", 32'(s_m1_rvalid), 32'h1);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      set_m0(vecs[v].m0_rs, vecs[v].m0_wm, vecs[v].m0_a, vecs[v].m0_d);
      set_m1(vecs[v].m1_rs, vecs[v].m1_wm, vecs[v].m1_a, vecs[v].m1_d);
      cycle();
      chk("vec_gnt", 32'({s_m0_gnt, s_m1_gnt}), 32'({vecs[v].e_g0, vecs[v].e_g1}));
      chk("vec_addr", s_addr, vecs[v].e_addr);
      chk("vec_strb", 32'({s_wmask, s_rstrb}), 32'({vecs[v].e_wm, vecs[v].e_rs}));
    end
    set_m1(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();

    // Reset in the middle of a read drops the return
    set_m0(1'b1, 4'h0, 32'h34, 32'h0);
    cycle();
    set_m0(1'b0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b0;
    cycle();
    chk("midrst_rvalid", 32'(s_m0_rvalid), 32'h0);
    resetn = 1'b1;
    cycle();
    chk("postrst_rvalid", 32'({s_m0_rvalid, s_m1_rvalid}), 32'h0);

`ifdef MEM_ARB_LOCK_EN
    // Locked 4-word M1 burst holds the bus against M0
    n = 0;
    for (int w = 0; w < 4; w++) begin
      m1_lock = 1'b1;
      set_m1(1'b0, 4'hF, 32'h200 + 32'(w * 4), 32'h1000 + 32'(w));
      if (w > 0) set_m0(1'b1, 4'h0, 32'h40, 32'h0);
      cycle();
      if (s_m1_gnt) n++;
    end
    chk("lock_burst", 32'(n), 32'd4);
    m1_lock = 1'b0;
    set_m1(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
    chk("lock_end_m0", 32'(s_m0_gnt), 32'h1);
    set_m0(1'b0, 4'h0, 32'h0, 32'h0);
    cycle();
`endif

    // Random traffic; a master holds its request until the model says it was granted
    for (int c = 0; c < 600; c++) begin
      if (last_e0 || !(m0_rstrb || (|m0_wmask))) begin
        rand_req(25, rs, wm, a, d); set_m0(rs, wm, a, d);
      end
      if (last_e1 || !(m1_rstrb || (|m1_wmask))) begin
        rand_req(45, rs, wm, a, d); set_m1(rs, wm, a, d);
      end
`ifdef MEM_ARB_LOCK_EN
      m1_lock = 1'($urandom_range(0, 3) == 0);
`endif
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
